// File: rtl/prog_mem_loader_if.sv
// Bundle of the signals between a program-image loader, its stream source and the memory
// write port.
//   start                          pulse that begins a load
//   in_data/in_valid/in_last       stream word, qualifier, end-of-image marker
//   in_ready                       loader accepts a word this cycle
//   mem_we/mem_addr/mem_wdata      memory write port
//   busy/done/overflow/word_count  load status
// slave  : the loader's view (consumes the stream, drives memory and status).
// master : the controller/source view (drives the stream and start, observes the rest).
interface prog_mem_loader_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
);

  logic                  start;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [ADDR_WIDTH:0]   word_count;

  modport slave (
    input  start,
    input  in_data,
    input  in_valid,
    input  in_last,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output busy,
    output done,
    output overflow,
    output word_count
  );

  modport master (
    output start,
    output in_data,
    output in_valid,
    output in_last,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  busy,
    input  done,
    input  overflow,
    input  word_count
  );

endinterface

// File: rtl/prog_mem_loader.sv
// Program-image loader. Accepts words from a valid/ready stream and writes them to
// consecutive memory addresses starting at BASE_ADDR, one registered write per accepted
// word, one cycle after the handshake. Reports completion, the number of words accepted
// and an overflow when the image does not fit between BASE_ADDR and the top of memory.
//
// Ports:
//   CLK  rising-edge clock
//   RST  synchronous active-high reset
//   bus  prog_mem_loader_if.slave: start, stream in (in_data/in_valid/in_last/in_ready),
//        memory write port (mem_we/mem_addr/mem_wdata), status (busy/done/overflow/
//        word_count)
//
// Capacity is 2^ADDR_WIDTH - BASE_ADDR words; BASE_ADDR must lie inside the memory.
module prog_mem_loader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned BASE_ADDR  = 0
) (
  input logic              CLK,
  input logic              RST,
  prog_mem_loader_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] PtrOne   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CountOne = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDone,
    StError
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  // Next-state and write-port logic. The write port registers are loaded only on a
  // handshake, so address and data hold their last values between writes.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (bus.start) begin
          state_d = StLoad;
          ptr_d   = BaseAddr;
          count_d = '0;
        end
      end

      StLoad: begin
        // in_ready is high throughout LOAD, so in_valid alone marks a handshake;
        // a start pulse here is deliberately ignored.
        if (bus.in_valid) begin
          we_d    = 1'b1;
          addr_d  = ptr_q;
          wdata_d = bus.in_data;
          count_d = count_q + CountOne;

          if (bus.in_last) begin
            state_d = StDone;
          end else if (ptr_q == '1) begin
            // Top of memory written and the image keeps going: stop rather than wrap.
            state_d = StError;
          end

          // Pointer saturates at the top address; leaving LOAD there never reuses it.
          if (ptr_q != '1) begin
            ptr_d = ptr_q + PtrOne;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Reset clears the pending write as well, so a handshake in the reset cycle never
  // reaches memory.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Status decodes straight from the state register, so done/overflow rise and busy
  // falls in the same cycle as the final write pulse.
  assign bus.in_ready   = (state_q == StLoad);
  assign bus.busy       = (state_q == StLoad);
  assign bus.done       = (state_q == StDone);
  assign bus.overflow   = (state_q == StError);
  assign bus.word_count = count_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader. Three instances share clock and reset:
//   u_a : defaults (ADDR_WIDTH 8, BASE_ADDR 0)  basic load, start mid-load, reset mid-load
//   u_b : BASE_ADDR 0x10                         stream with bubbles
//   u_c : ADDR_WIDTH 3, BASE_ADDR 4              overflow and exact fit
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point
// after the following edge.
module tb_prog_mem_loader;

  logic clk;
  logic rst;

  int n_checks;
  int n_errors;

  prog_mem_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus_a ();
  prog_mem_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus_b ();
  prog_mem_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) bus_c ();

  prog_mem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .BASE_ADDR(0)) u_a (
    .CLK (clk),
    .RST (rst),
    .bus (bus_a)
  );

  prog_mem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .BASE_ADDR(16)) u_b (
    .CLK (clk),
    .RST (rst),
    .bus (bus_b)
  );

  prog_mem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .BASE_ADDR(4)) u_c (
    .CLK (clk),
    .RST (rst),
    .bus (bus_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] words_a [4];
  bit          pat_b   [5];
  int          n;

  initial begin
    n_checks = 0;
    n_errors = 0;
    words_a = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'hDEAD_BEEF};
    pat_b   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    bus_a.start = 0; bus_a.in_valid = 0; bus_a.in_last = 0; bus_a.in_data = '0;
    bus_b.start = 0; bus_b.in_valid = 0; bus_b.in_last = 0; bus_b.in_data = '0;
    bus_c.start = 0; bus_c.in_valid = 0; bus_c.in_last = 0; bus_c.in_data = '0;

    // Reset state, with valid/start asserted to show reset wins.
    rst = 1;
    bus_a.start = 1;
    bus_a.in_valid = 1;
    tick();
    tick();
    check("rst_ready",    bus_a.in_ready,   0);
    check("rst_we",       bus_a.mem_we,     0);
    check("rst_addr",     bus_a.mem_addr,   0);
    check("rst_wdata",    bus_a.mem_wdata,  0);
    check("rst_busy",     bus_a.busy,       0);
    check("rst_done",     bus_a.done,       0);
    check("rst_ovf",      bus_a.overflow,   0);
    check("rst_count",    bus_a.word_count, 0);
    bus_a.start = 0;
    bus_a.in_valid = 0;
    rst = 0;
    tick();
    check("idle_ready",   bus_a.in_ready,   0);

    // Basic load: four back-to-back words, last on the fourth.
    bus_a.start = 1;
    tick();
    bus_a.start = 0;
    check("a_busy",       bus_a.busy,       1);
    check("a_ready",      bus_a.in_ready,   1);
    check("a_we_pre",     bus_a.mem_we,     0);
    for (int i = 0; i < 4; i++) begin
      bus_a.in_valid = 1;
      bus_a.in_data  = words_a[i];
      bus_a.in_last  = (i == 3);
      tick();
      check($sformatf("a_we%0d", i),    bus_a.mem_we,    1);
      check($sformatf("a_addr%0d", i),  bus_a.mem_addr,  i);
      check($sformatf("a_wdata%0d", i), bus_a.mem_wdata, words_a[i]);
    end
    bus_a.in_valid = 0;
    bus_a.in_last  = 0;
    check("a_done",       bus_a.done,       1);
    check("a_busy_end",   bus_a.busy,       0);
    check("a_ready_end",  bus_a.in_ready,   0);
    check("a_count",      bus_a.word_count, 4);
    bus_a.in_valid = 1;
    bus_a.in_data  = 32'hFFFF_0000;
    tick();
    bus_a.in_valid = 0;
    check("a_we_after",   bus_a.mem_we,     0);
    check("a_addr_hold",  bus_a.mem_addr,   3);
    check("a_wdata_hold", bus_a.mem_wdata,  32'hDEAD_BEEF);
    check("a_done_hold",  bus_a.done,       1);
    check("a_count_hold", bus_a.word_count, 4);

    // Bubbles on u_b: valid pattern 1,0,0,1,1 carries three words from 0x10.
    bus_b.start = 1;
    tick();
    bus_b.start = 0;
    n = 0;
    for (int k = 0; k < 5; k++) begin
      bus_b.in_valid = pat_b[k];
      bus_b.in_data  = pat_b[k] ? 32'hA0 + n : 32'hBAD0_0000;
      bus_b.in_last  = pat_b[k] && (n == 2);
      tick();
      if (pat_b[k]) n++;
      check($sformatf("b_we%0d", k),    bus_b.mem_we,    pat_b[k]);
      check($sformatf("b_addr%0d", k),  bus_b.mem_addr,  16 + n - 1);
      check($sformatf("b_wdata%0d", k), bus_b.mem_wdata, 32'hA0 + n - 1);
    end
    bus_b.in_valid = 0;
    bus_b.in_last  = 0;
    check("b_done",       bus_b.done,       1);
    check("b_count",      bus_b.word_count, 3);

    // Overflow on u_c: five words, none last, only addresses 4..7 exist.
    bus_c.start = 1;
    tick();
    bus_c.start = 0;
    for (int i = 0; i < 5; i++) begin
      bus_c.in_valid = 1;
      bus_c.in_data  = 32'hC0 + i;
      bus_c.in_last  = 0;
      tick();
      if (i < 4) begin
        check($sformatf("c_we%0d", i),    bus_c.mem_we,    1);
        check($sformatf("c_addr%0d", i),  bus_c.mem_addr,  4 + i);
        check($sformatf("c_wdata%0d", i), bus_c.mem_wdata, 32'hC0 + i);
      end else begin
        check("c_we_5th",   bus_c.mem_we,   0);
        check("c_addr_5th", bus_c.mem_addr, 7);
      end
      if (i == 3) begin
        check("c_ovf",      bus_c.overflow, 1);
        check("c_ready",    bus_c.in_ready, 0);
        check("c_busy",     bus_c.busy,     0);
        check("c_done",     bus_c.done,     0);
      end
    end
    bus_c.in_valid = 0;
    check("c_count",      bus_c.word_count, 4);
    check("c_ovf_hold",   bus_c.overflow,   1);

    // Exact fit on u_c: four words, last on the fourth.
    bus_c.start = 1;
    tick();
    bus_c.start = 0;
    check("cf_ovf_clr",   bus_c.overflow,   0);
    check("cf_count_clr", bus_c.word_count, 0);
    check("cf_busy",      bus_c.busy,       1);
    for (int i = 0; i < 4; i++) begin
      bus_c.in_valid = 1;
      bus_c.in_data  = 32'hE0 + i;
      bus_c.in_last  = (i == 3);
      tick();
      check($sformatf("cf_we%0d", i),   bus_c.mem_we,   1);
      check($sformatf("cf_addr%0d", i), bus_c.mem_addr, 4 + i);
    end
    bus_c.in_valid = 0;
    bus_c.in_last  = 0;
    check("cf_done",      bus_c.done,       1);
    check("cf_ovf",       bus_c.overflow,   0);
    check("cf_count",     bus_c.word_count, 4);

    // start mid-LOAD on u_a is ignored.
    bus_a.start = 1;
    tick();
    bus_a.start = 0;
    for (int i = 0; i < 2; i++) begin
      bus_a.in_valid = 1;
      bus_a.in_data  = 32'h50 + i;
      tick();
    end
    bus_a.in_valid = 0;
    bus_a.start    = 1;
    tick();
    bus_a.start = 0;
    check("s_busy",       bus_a.busy,       1);
    check("s_we_gap",     bus_a.mem_we,     0);
    check("s_count2",     bus_a.word_count, 2);
    for (int i = 2; i < 4; i++) begin
      bus_a.in_valid = 1;
      bus_a.in_data  = 32'h50 + i;
      bus_a.in_last  = (i == 3);
      tick();
      check($sformatf("s_addr%0d", i),  bus_a.mem_addr,  i);
      check($sformatf("s_wdata%0d", i), bus_a.mem_wdata, 32'h50 + i);
    end
    bus_a.in_valid = 0;
    bus_a.in_last  = 0;
    check("s_done",       bus_a.done,       1);
    check("s_count4",     bus_a.word_count, 4);

    // Restart after DONE clears status and begins again at the base address.
    bus_a.start = 1;
    tick();
    bus_a.start = 0;
    check("r_done_clr",   bus_a.done,       0);
    check("r_count_clr",  bus_a.word_count, 0);
    for (int i = 0; i < 2; i++) begin
      bus_a.in_valid = 1;
      bus_a.in_data  = 32'h60 + i;
      tick();
      check($sformatf("r_addr%0d", i),  bus_a.mem_addr,  i);
    end

    // Reset in a handshake cycle after two words: the pending write is dropped.
    bus_a.in_data = 32'h62;
    rst = 1;
    tick();
    rst = 0;
    check("x_we",         bus_a.mem_we,     0);
    check("x_addr",       bus_a.mem_addr,   0);
    check("x_wdata",      bus_a.mem_wdata,  0);
    check("x_count",      bus_a.word_count, 0);
    check("x_busy",       bus_a.busy,       0);
    check("x_ready",      bus_a.in_ready,   0);
    tick();
    check("x_ready_idle", bus_a.in_ready,   0);
    check("x_we_idle",    bus_a.mem_we,     0);
    bus_a.in_valid = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
